// File: rtl/multicycle_controller_if.sv
// Control and handshake bundle between the multicycle controller (master) and
// the datapath/memory side (slave).
interface multicycle_controller_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             halt_req;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem2reg;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic             timeout;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready, halt_req,
        output imem_req, ir_write, pc_write, alu_src, alu_op, mem_read, mem_write,
               reg_write, mem2reg, busy, halted, illegal, timeout, state_dbg, retired
    );

    modport slave (
        output opcode, mem_ready, halt_req,
        input  imem_req, ir_write, pc_write, alu_src, alu_op, mem_read, mem_write,
               reg_write, mem2reg, busy, halted, illegal, timeout, state_dbg, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB with a
// memory watchdog, halt handling at instruction boundaries and a retired counter.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_I    = 3'd2,
        C_LD   = 3'd3,
        C_ST   = 3'd4
    } class_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    state_t           state;
    class_t           cls;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retired;
    logic             illegal;
    logic             timeout;
    logic             pc_step;
    state_t           boundary;

    function automatic class_t decode_class(input logic [6:0] op);
        case (op)
            OP_R:    return C_R;
            OP_I:    return C_I;
            OP_LD:   return C_LD;
            OP_ST:   return C_ST;
            default: return C_NONE;
        endcase
    endfunction

    // A store retires in its ready MEM cycle; every other class retires in WB.
    assign pc_step  = (state == S_WB) ||
                      (state == S_MEM && cls == C_ST && bus.mem_ready);
    assign boundary = bus.halt_req ? S_HALT : S_FETCH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            cls      <= C_NONE;
            wait_cnt <= '0;
            retired  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on the pre-edge values, independent of statement order.
            if (pc_step) retired <= retired + CNT_W'(1);
            case (state)
                S_FETCH, S_MEM: begin
                    if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        if (state == S_FETCH)   state <= S_DECODE;
                        else if (cls == C_ST)   state <= boundary;
                        else                    state <= S_WB;
                    end else if (wait_cnt == LIMIT) begin
                        wait_cnt <= '0;
                        timeout  <= 1'b1;
                        state    <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls <= decode_class(bus.opcode);
                    if (decode_class(bus.opcode) == C_NONE) begin
                        illegal <= 1'b1;
                        state   <= S_ERROR;
                    end else begin
                        state   <= S_EXEC;
                    end
                end
                S_EXEC:  state <= (cls == C_LD || cls == C_ST) ? S_MEM : S_WB;
                S_WB:    state <= boundary;
                S_HALT:  if (!bus.halt_req) state <= S_FETCH;
                S_ERROR: state <= S_ERROR;
                default: state <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        bus.imem_req  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.alu_src   = 1'b0;
        bus.alu_op    = 2'b00;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.reg_write = 1'b0;
        bus.mem2reg   = 1'b0;
        if (reset) begin
            bus.pc_write = pc_step;
            case (state)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_write = bus.mem_ready;
                end
                S_EXEC, S_MEM, S_WB: begin
                    bus.alu_src = (cls != C_R);
                    bus.alu_op  = (cls == C_R || cls == C_I) ? 2'b10 : 2'b00;
                    if (state == S_MEM) begin
                        bus.mem_read  = (cls == C_LD);
                        bus.mem_write = (cls == C_ST);
                    end
                    if (state == S_WB) begin
                        bus.reg_write = 1'b1;
                        bus.mem2reg   = (cls == C_LD);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                           (state == S_MEM)   || (state == S_WB);
    assign bus.halted    = (state == S_HALT);
    assign bus.illegal   = illegal;
    assign bus.timeout   = timeout;
    assign bus.state_dbg = state;
    assign bus.retired   = retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction reference model expands each
// instruction into its expected cycle trace, replayed against the DUT.
module tb_multicycle_controller;
    localparam int CNT_W       = 16;
    localparam int MEM_TIMEOUT = 15;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

    multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_write, pc_write, alu_src;
        logic [1:0] alu_op;
        logic       mem_read, mem_write, reg_write, mem2reg;
        logic       busy, halted, illegal, timeout;
    } obs_t;

    typedef struct {
        obs_t       exp;
        logic       rdy;
        logic       hlt;
        logic [6:0] op;
    } step_t;

    step_t trace[$];
    int    checks      = 0;
    int    failures    = 0;
    int    exp_retired = 0;

    function automatic logic rnd_bit();
        return 1'($urandom % 2);
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st        = bus.state_dbg;
        o.imem_req  = bus.imem_req;
        o.ir_write  = bus.ir_write;
        o.pc_write  = bus.pc_write;
        o.alu_src   = bus.alu_src;
        o.alu_op    = bus.alu_op;
        o.mem_read  = bus.mem_read;
        o.mem_write = bus.mem_write;
        o.reg_write = bus.reg_write;
        o.mem2reg   = bus.mem2reg;
        o.busy      = bus.busy;
        o.halted    = bus.halted;
        o.illegal   = bus.illegal;
        o.timeout   = bus.timeout;
        return o;
    endfunction

    task automatic push_step(input obs_t e, input logic rdy, input logic hlt, input logic [6:0] op);
        step_t s;
        s.exp = e;
        s.rdy = rdy;
        s.hlt = hlt;
        s.op  = op;
        trace.push_back(s);
    endtask

    // Reference model: one instruction of class cls (0 R, 1 I, 2 LD, 3 ST) with fw
    // unready fetch cycles, mw unready MEM cycles and halt_req=h when it completes.
    task automatic append_instr(input int cls, input int fw, input int mw, input bit h);
        obs_t       o;
        logic [6:0] op_tab [4] = '{OP_R, OP_I, OP_LD, OP_ST};
        logic       asrc = (cls != 0);
        logic [1:0] aop  = (cls <= 1) ? 2'b10 : 2'b00;
        for (int i = 0; i <= fw; i++) begin
            o = '0; o.st = 3'd0; o.busy = 1'b1; o.imem_req = 1'b1; o.ir_write = (i == fw);
            push_step(o, i == fw, rnd_bit(), rnd_op());
        end
        o = '0; o.st = 3'd1; o.busy = 1'b1;
        push_step(o, rnd_bit(), rnd_bit(), op_tab[cls]);
        o = '0; o.st = 3'd2; o.busy = 1'b1; o.alu_src = asrc; o.alu_op = aop;
        push_step(o, rnd_bit(), h | rnd_bit(), rnd_op());
        if (cls >= 2) begin
            for (int i = 0; i <= mw; i++) begin
                o = '0; o.st = 3'd3; o.busy = 1'b1; o.alu_src = asrc; o.alu_op = aop;
                o.mem_read = (cls == 2); o.mem_write = (cls == 3);
                o.pc_write = (cls == 3) && (i == mw);
                push_step(o, i == mw, h | rnd_bit(), rnd_op());
            end
        end
        if (cls != 3) begin
            o = '0; o.st = 3'd4; o.busy = 1'b1; o.alu_src = asrc; o.alu_op = aop;
            o.reg_write = 1'b1; o.pc_write = 1'b1; o.mem2reg = (cls == 2);
            push_step(o, rnd_bit(), h, rnd_op());
        end
        trace[trace.size() - 1].hlt = h;
        if (h) begin
            int k = 1 + int'($urandom % 3);
            o = '0; o.st = 3'd5; o.halted = 1'b1;
            for (int i = 0; i < k; i++) push_step(o, rnd_bit(), 1'b1, rnd_op());
            push_step(o, rnd_bit(), 1'b0, rnd_op());
        end
    endtask

    task automatic drive_step(input step_t s, output obs_t o, output logic [CNT_W-1:0] r);
        bus.mem_ready = s.rdy;
        bus.halt_req  = s.hlt;
        bus.opcode    = s.op;
        #1;
        o = sample();
        r = bus.retired;
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o;
        bus.mem_ready = 1'b1;
        bus.halt_req  = 1'b0;
        bus.opcode    = OP_R;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            o = sample();
            o.busy = 1'b0;
            checks++;
            if (o !== obs_t'('0)) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %h expected %h", i, o, obs_t'('0));
            end
            checks++;
            if (bus.retired !== '0) begin
                failures++;
                $display("FAIL reset_retired: got %0d expected 0", bus.retired);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        exp_retired = 0;
    endtask

    task automatic test_r_type();
        obs_t o; logic [CNT_W-1:0] r;
        trace.delete();
        append_instr(0, 0, 0, 1'b0);
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL r_type step %0d: got %h expected %h", i, o, trace[i].exp);
            end
            checks++;
            if (r !== CNT_W'(exp_retired)) begin
                failures++; $display("FAIL r_type_retired step %0d: got %0d expected %0d", i, r, exp_retired);
            end
            if (trace[i].exp.pc_write) exp_retired++;
        end
        bus.mem_ready = 1'b0; #1;
        checks++;
        if (bus.state_dbg !== 3'd0 || bus.retired !== CNT_W'(1)) begin
            failures++;
            $display("FAIL r_type_end: got state %0d retired %0d expected state 0 retired 1", bus.state_dbg, bus.retired);
        end
    endtask

    task automatic test_load_wait();
        obs_t o; logic [CNT_W-1:0] r;
        trace.delete();
        append_instr(2, 0, 3, 1'b0);
        checks++;
        if (trace.size() != 8) begin
            failures++; $display("FAIL load_latency: got %0d expected 8", trace.size());
        end
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL load_wait step %0d: got %h expected %h", i, o, trace[i].exp);
            end
            checks++;
            if (r !== CNT_W'(exp_retired)) begin
                failures++; $display("FAIL load_retired step %0d: got %0d expected %0d", i, r, exp_retired);
            end
            if (trace[i].exp.pc_write) exp_retired++;
        end
        bus.mem_ready = 1'b0; #1;
        checks++;
        if (bus.state_dbg !== 3'd0) begin
            failures++; $display("FAIL load_end_state: got %0d expected 0", bus.state_dbg);
        end
    endtask

    task automatic test_store();
        obs_t o; logic [CNT_W-1:0] r;
        trace.delete();
        append_instr(3, 0, 0, 1'b0);
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL store step %0d: got %h expected %h", i, o, trace[i].exp);
            end
            checks++;
            if (r !== CNT_W'(exp_retired)) begin
                failures++; $display("FAIL store_retired step %0d: got %0d expected %0d", i, r, exp_retired);
            end
            if (trace[i].exp.pc_write) exp_retired++;
        end
        bus.mem_ready = 1'b0; #1;
        checks++;
        if (bus.state_dbg !== 3'd0) begin
            failures++; $display("FAIL store_end_state: got %0d expected 0", bus.state_dbg);
        end
    endtask

    task automatic test_halt();
        obs_t o; logic [CNT_W-1:0] r;
        trace.delete();
        append_instr(1, 1, 0, 1'b1);
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL halt step %0d: got %h expected %h", i, o, trace[i].exp);
            end
            checks++;
            if (r !== CNT_W'(exp_retired)) begin
                failures++; $display("FAIL halt_retired step %0d: got %0d expected %0d", i, r, exp_retired);
            end
            if (trace[i].exp.pc_write) exp_retired++;
        end
        bus.mem_ready = 1'b0; #1;
        checks++;
        if (bus.state_dbg !== 3'd0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_release: got state %0d halted %0b expected state 0 halted 0", bus.state_dbg, bus.halted);
        end
    endtask

    task automatic test_random();
        obs_t o; logic [CNT_W-1:0] r;
        trace.delete();
        append_instr(0, MEM_TIMEOUT, 0, 1'b0);
        append_instr(2, 0, MEM_TIMEOUT, 1'b0);
        append_instr(3, 2, MEM_TIMEOUT, 1'b0);
        for (int n = 0; n < 40; n++) begin
            append_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 4)), ($urandom % 5) == 0);
        end
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL random step %0d: got %h expected %h", i, o, trace[i].exp);
            end
            checks++;
            if (r !== CNT_W'(exp_retired)) begin
                failures++; $display("FAIL random_retired step %0d: got %0d expected %0d", i, r, exp_retired);
            end
            if (trace[i].exp.pc_write) exp_retired++;
        end
    endtask

    task automatic test_illegal();
        obs_t o, e; logic [CNT_W-1:0] r;
        trace.delete();
        e = '0; e.st = 3'd0; e.busy = 1'b1; e.imem_req = 1'b1; e.ir_write = 1'b1;
        push_step(e, 1'b1, 1'b0, rnd_op());
        e = '0; e.st = 3'd1; e.busy = 1'b1;
        push_step(e, rnd_bit(), 1'b0, 7'b1111111);
        e = '0; e.st = 3'd6; e.illegal = 1'b1;
        for (int i = 0; i < 20; i++) push_step(e, rnd_bit(), rnd_bit(), rnd_op());
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL illegal step %0d: got %h expected %h", i, o, trace[i].exp);
            end
        end
        test_reset();
        #1;
        checks++;
        if (bus.illegal !== 1'b0 || bus.state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL illegal_cleared: got illegal %0b state %0d expected 0 0", bus.illegal, bus.state_dbg);
        end
    endtask

    task automatic test_timeout();
        obs_t o, e; logic [CNT_W-1:0] r;
        trace.delete();
        e = '0; e.st = 3'd0; e.busy = 1'b1; e.imem_req = 1'b1;
        for (int i = 0; i <= MEM_TIMEOUT; i++) push_step(e, 1'b0, rnd_bit(), rnd_op());
        e = '0; e.st = 3'd6; e.timeout = 1'b1;
        for (int i = 0; i < 4; i++) push_step(e, rnd_bit(), rnd_bit(), rnd_op());
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL timeout step %0d: got %h expected %h", i, o, trace[i].exp);
            end
        end
        test_reset();
        #1;
        checks++;
        if (bus.timeout !== 1'b0 || bus.state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL timeout_cleared: got timeout %0b state %0d expected 0 0", bus.timeout, bus.state_dbg);
        end
    endtask

    task automatic test_reset_mid_mem();
        obs_t o; logic [CNT_W-1:0] r;
        trace.delete();
        append_instr(2, 0, 6, 1'b0);
        while (trace.size() > 5) void'(trace.pop_back());
        foreach (trace[i]) begin
            drive_step(trace[i], o, r);
            checks++;
            if (o !== trace[i].exp) begin
                failures++; $display("FAIL mid_mem step %0d: got %h expected %h", i, o, trace[i].exp);
            end
        end
        test_reset();
        #1;
        checks++;
        if (bus.state_dbg !== 3'd0 || bus.retired !== '0) begin
            failures++;
            $display("FAIL mid_mem_abort: got state %0d retired %0d expected 0 0", bus.state_dbg, bus.retired);
        end
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.halt_req  = 1'b0;
        bus.opcode    = '0;
        @(negedge clk);
        test_reset();
        test_r_type();
        test_load_wait();
        test_store();
        test_halt();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences a multi-cycle version of the processor datapath, one instruction at a time: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Replaces the single-cycle opcode decoder. It drives the existing alu_op / alu_src / mem2reg / reg_write / mem_read / mem_write controls plus pc_write / ir_write sequencing strobes.
- Memory accesses use a hold-until-ready handshake with a timeout watchdog.
- Also provides halt request handling and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15, cycles a FETCH or MEM access may wait on mem_ready before ERROR (1..255).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  in  7  instruction[6:0] from IR; sampled in DECODE only.
- mem_ready  in  1  memory completion; meaningful only in FETCH/MEM.
- halt_req  in  1  level request to stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  IR load strobe.
- pc_write  out  1  PC+4 update strobe.
- alu_src  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  to ALUController.
- mem_read  out  1  data load request.
- mem_write  out  1  data store request.
- reg_write  out  1  register file write enable.
- mem2reg  out  1  1 = writeback from memory.
- busy  out  1  1 in FETCH..WB.
- halted  out  1  1 in HALT.
- illegal  out  1  sticky, unsupported opcode seen.
- timeout  out  1  sticky, memory watchdog expired.
- state_dbg  out  3  current state encoding.
- retired  out  CNT_W  instructions completed.

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, ERROR = 6. Encoding 7 is unreachable; if entered, go to ERROR.
- Reset (reset = 0, asynchronous):
  - state = FETCH.
  - Opcode class register cleared; wait counter = 0; retired = 0; illegal = 0; timeout = 0.
  - All strobes are 0 while reset is held.
  - Reset mid-instruction aborts it with no pc_write.
- Opcode classes, latched in DECODE:
  - R = 0110011.
  - I = 0010011.
  - LD = 0000011.
  - ST = 0100011.
  - Anything else is illegal.
- FETCH:
  - imem_req = 1, held until mem_ready = 1.
  - On the mem_ready cycle, ir_write = 1 for that cycle only; next state is DECODE.
- DECODE (1 cycle):
  - Latch class from opcode.
  - If illegal: set illegal and go to ERROR.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - R: alu_src = 0, alu_op = 10.
  - I: alu_src = 1, alu_op = 10.
  - LD/ST: alu_src = 1, alu_op = 00.
  - R/I go to WB; LD/ST go to MEM.
- alu_src/alu_op remain at the class values through MEM and WB. They are 0/00 in FETCH, DECODE, HALT and ERROR.
- MEM:
  - LD: mem_read = 1, held until mem_ready; then go to WB.
  - ST: mem_write = 1, held until mem_ready; in the ready cycle pc_write = 1, then go to the boundary state.
- WB (1 cycle):
  - reg_write = 1 and pc_write = 1.
  - mem2reg = 1 for LD only.
  - Then go to the boundary state.
- Boundary state: HALT if halt_req = 1 in the completing cycle, else FETCH.
- HALT: halted = 1 and all strobes 0. Returns to FETCH in the first cycle halt_req = 0. halt_req asserted mid-instruction never truncates the instruction.
- Watchdog:
  - The counter increments each cycle in FETCH/MEM with mem_ready = 0, and clears on state change.
  - If the counter == MEM_TIMEOUT and mem_ready = 0: set timeout and go to ERROR.
  - mem_ready = 1 in the same cycle as the limit wins (access completes).
- ERROR: all strobes 0 and busy = 0. Exit only via reset.
- retired increments by 1 on every pc_write cycle and wraps modulo 2^CNT_W.
- mem_ready in DECODE, EXEC, WB, HALT or ERROR is ignored.
- Latency with mem_ready held at 1: R/I = 4 cycles, ST = 4, LD = 5 (FETCH to next FETCH).
- All outputs are decoded from registered state/class; no combinational path from opcode or halt_req to outputs.

Test Plan:
- Reset release, mem_ready = 1, opcode = 0110011 -> state sequence 0,1,2,4,0; ir_write in cycle 1; reg_write + pc_write in WB; alu_op = 10, alu_src = 0; retired = 1.
- opcode = 0000011, mem_ready low for 3 MEM cycles -> mem_read held 4 cycles; WB has mem2reg = 1, reg_write = 1; alu_op = 00, alu_src = 1 through WB; latency 8 cycles.
- opcode = 0100011, mem_ready = 1 -> mem_write + pc_write in the same MEM cycle; reg_write never 1; return to FETCH after 4 cycles.
- opcode = 1111111 -> illegal = 1, state = 6, all strobes 0 for 20 cycles; reset = 0 clears illegal, state = 0.
- mem_ready stuck 0 in FETCH, MEM_TIMEOUT = 15 -> timeout = 1, ERROR after exactly 16 FETCH cycles. Variant: mem_ready = 1 on the 16th cycle -> no timeout.
- halt_req = 1 asserted in EXEC of an I-type -> WB completes, state = HALT, halted = 1; drop halt_req -> FETCH next cycle. Variant: reset = 0 pulsed mid-MEM -> FETCH, retired unchanged = 0.
